matmul_result_drain: RTL and testbench

//  Downstream stage of the matrix-multiply controller/MAC datapath. Captures each

---
 rtl/matmul_result_drain.sv | 153 +++++++++++++++
 tb/tb_matmul_result_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_drain.sv
// matmul_result_drain: collects finished MAC accumulators into a frame buffer,
// then saturates and streams the complete frame out in index order over a
// valid/ready port.
module matmul_result_drain #(
  parameter int N_RESULTS = 9,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    res_we,
  input  logic [IDX_W-1:0]        res_idx,
  input  logic signed [ACC_W-1:0] res_data,
  output logic [OUT_W-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    dout_sat,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  localparam logic [N_RESULTS-1:0] ALL_FILLED = {N_RESULTS{1'b1}};
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(N_RESULTS - 1);
  localparam logic [IDX_W-1:0]     NUM_IDX    = IDX_W'(N_RESULTS);

  // Saturation thresholds expressed at accumulator width, and the clamped codes.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                  state;
  logic [N_RESULTS-1:0]    filled;
  logic [IDX_W-1:0]        rd_ptr;
  logic signed [ACC_W-1:0] result_mem [N_RESULTS];

  logic                    idx_ok;
  logic [N_RESULTS-1:0]    wr_onehot;
  logic                    mem_we;
  logic signed [ACC_W-1:0] cur_val;
  logic [OUT_W-1:0]        sat_val;
  logic                    sat_flag;

  // Decode the incoming index into a one-hot bitmap slot; out-of-range gives zero.
  always_comb begin
    idx_ok    = (res_idx < NUM_IDX);
    wr_onehot = '0;
    for (int i = 0; i < N_RESULTS; i++) begin
      wr_onehot[i] = res_we && idx_ok && (res_idx == IDX_W'(i));
    end
  end

  // A capture lands in the buffer in COLLECT, or as the first write of a new frame.
  assign mem_we = reset && res_we && idx_ok && (frame_start || (state == COLLECT));

  // Result storage; contents deliberately survive reset since the bitmap gates use.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      result_mem[res_idx] <= res_data;
    end
  end

  // Frame control: bitmap, read pointer, sticky error and state sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      filled <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else if (frame_start) begin
      filled <= wr_onehot;
      rd_ptr <= '0;
      err    <= res_we && !idx_ok;
      state  <= (wr_onehot == ALL_FILLED) ? DRAIN : COLLECT;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        COLLECT: begin
          if (res_we) begin
            if (!idx_ok) begin
              err <= 1'b1;
            end else begin
              if ((filled & wr_onehot) != '0) begin
                err <= 1'b1;
              end
              filled <= filled | wr_onehot;
              if ((filled | wr_onehot) == ALL_FILLED) begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (res_we) begin
            err <= 1'b1;
          end
          if (dout_ready) begin
            if (rd_ptr == LAST_IDX) begin
              rd_ptr <= '0;
              state  <= DONE;
            end else begin
              rd_ptr <= rd_ptr + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Clamp the entry under the read pointer to the signed output range.
  always_comb begin
    cur_val  = result_mem[rd_ptr];
    sat_val  = cur_val[OUT_W-1:0];
    sat_flag = 1'b0;
    if (cur_val > SAT_MAX) begin
      sat_val  = OUT_MAX;
      sat_flag = 1'b1;
    end else if (cur_val < SAT_MIN) begin
      sat_val  = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  // Output port: data fields are forced to zero outside DRAIN.
  always_comb begin
    dout_valid = (state == DRAIN);
    busy       = (state == COLLECT) || (state == DRAIN);
    done       = (state == DONE);
    dout       = dout_valid ? sat_val : '0;
    dout_sat   = dout_valid && sat_flag;
    dout_last  = dout_valid && (rd_ptr == LAST_IDX);
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// tb_matmul_result_drain: directed scoreboard bench for matmul_result_drain.
module tb_matmul_result_drain;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        l;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        res_we;
  logic [3:0]  res_idx;
  logic [31:0] res_data;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        dout_sat;
  logic        busy;
  logic        done;
  logic        err;

  int   total = 0;
  int   bad = 0;
  int   model [9];
  exp_t sbq [$];
  int   cyc;

  matmul_result_drain dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .res_we      (res_we),
    .res_idx     (res_idx),
    .res_data    (res_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .dout_sat    (dout_sat),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, then release the strobes.
  task automatic applyStimulus(input logic fs, input logic we, input logic [3:0] idx, input int data);
    frame_start = fs;
    res_we      = we;
    res_idx     = idx;
    res_data    = data;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    res_we      = 1'b0;
  endtask

  task automatic writeEntry(input int idx, input int data);
    applyStimulus(1'b0, 1'b1, 4'(idx), data);
    model[idx] = data;
  endtask

  // Reference clamp to a signed 16-bit result.
  function automatic exp_t modelEntry(input int v, input bit last);
    exp_t e;
    if (v > 32767) begin
      e.d = 16'h7fff;
      e.s = 1'b1;
    end else if (v < -32768) begin
      e.d = 16'h8000;
      e.s = 1'b1;
    end else begin
      e.d = 16'(v);
      e.s = 1'b0;
    end
    e.l = last;
    return e;
  endfunction

  task automatic pushFrame();
    for (int i = 0; i < 9; i++) sbq.push_back(modelEntry(model[i], i == 8));
  endtask

  // Drain against the scoreboard; mode 1 toggles ready starting low.
  task automatic drainFrame(input string tag, input int mode, input int limit, input bit full,
                            output int cycles);
    exp_t e;
    cycles = 0;
    while (sbq.size() > 0 && cycles < limit) begin
      dout_ready = (mode == 0) ? 1'b1 : ((cycles % 2) == 1);
      e = sbq[0];
      checkOutput({tag, "_valid"}, 32'(dout_valid), 32'd1);
      checkOutput({tag, "_dout"},  32'(dout), 32'(e.d));
      checkOutput({tag, "_sat"},   32'(dout_sat), 32'(e.s));
      checkOutput({tag, "_last"},  32'(dout_last), 32'(e.l));
      if (dout_ready) void'(sbq.pop_front());
      @(posedge clk);
      #1;
      cycles++;
    end
    dout_ready = 1'b0;
    if (full) begin
      checkOutput({tag, "_left"}, 32'(sbq.size()), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_vdone"}, 32'(dout_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0; res_we = 1'b0; res_idx = '0; res_data = '0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_done",  32'(done), 32'd0);
    checkOutput("rst_err",   32'(err), 32'd0);
    checkOutput("rst_dout",  32'(dout), 32'd0);
    reset = 1'b1;

    // Write while idle is ignored without raising an error.
    applyStimulus(1'b0, 1'b1, 4'd0, 55);
    checkOutput("idle_we_err",  32'(err), 32'd0);
    checkOutput("idle_we_busy", 32'(busy), 32'd0);

    // Normal frame, full-rate drain.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    checkOutput("n_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) writeEntry(i, i + 1);
    checkOutput("n_notyet", 32'(dout_valid), 32'd0);
    writeEntry(8, 9);
    pushFrame();
    drainFrame("normal", 0, 40, 1'b1, cyc);
    checkOutput("normal_cycles", 32'(cyc), 32'd9);

    // Out-of-order fill with throttled consumer.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    begin
      int order [9] = '{8, 0, 4, 1, 7, 2, 6, 3, 5};
      for (int i = 0; i < 9; i++) writeEntry(order[i], order[i] * 1000 - 3000);
    end
    checkOutput("ooo_err", 32'(err), 32'd0);
    pushFrame();
    drainFrame("ooo", 1, 60, 1'b1, cyc);
    checkOutput("ooo_cycles", 32'(cyc), 32'd18);

    // Saturation including exact boundaries.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    begin
      int vals [9] = '{40000, -40000, -5, 32767, -32768, 32768, -32769, 0, 123};
      for (int i = 0; i < 9; i++) writeEntry(i, vals[i]);
    end
    pushFrame();
    drainFrame("sat", 0, 40, 1'b1, cyc);

    // Bad index: error set, bitmap untouched so frame needs all nine real writes.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    applyStimulus(1'b0, 1'b1, 4'd12, 999);
    checkOutput("badidx_err",  32'(err), 32'd1);
    checkOutput("badidx_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) writeEntry(i, 10 + i);
    checkOutput("badidx_collect", 32'(dout_valid), 32'd0);
    writeEntry(8, 18);
    pushFrame();
    drainFrame("badidx", 0, 40, 1'b1, cyc);

    // Duplicate index: error set, later data wins.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    checkOutput("dup_clr", 32'(err), 32'd0);
    writeEntry(3, 7);
    checkOutput("dup_first", 32'(err), 32'd0);
    writeEntry(3, 11);
    checkOutput("dup_err", 32'(err), 32'd1);
    for (int i = 0; i < 9; i++) if (i != 3) writeEntry(i, 20 + i);
    pushFrame();
    drainFrame("dup", 0, 40, 1'b1, cyc);

    // Write during DRAIN: error set, buffer and output unchanged.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    for (int i = 0; i < 9; i++) writeEntry(i, 300 + i);
    pushFrame();
    checkOutput("dw_clean", 32'(err), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'd0, 999);
    checkOutput("dw_err",  32'(err), 32'd1);
    checkOutput("dw_dout", 32'(dout), 32'd300);
    drainFrame("dw", 0, 40, 1'b1, cyc);

    // Reset after three handshakes with err set.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    applyStimulus(1'b0, 1'b1, 4'd12, 1);
    for (int i = 0; i < 9; i++) writeEntry(i, 50 + i);
    pushFrame();
    drainFrame("pre_rst", 0, 3, 1'b0, cyc);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    checkOutput("mid_rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("mid_rst_busy",  32'(busy), 32'd0);
    checkOutput("mid_rst_err",   32'(err), 32'd0);
    checkOutput("mid_rst_done",  32'(done), 32'd0);

    // frame_start with a write in DRAIN: the write opens the new frame.
    applyStimulus(1'b1, 1'b0, 4'd0, 0);
    for (int i = 0; i < 9; i++) writeEntry(i, 70 + i);
    pushFrame();
    drainFrame("pre_fs", 0, 2, 1'b0, cyc);
    applyStimulus(1'b0, 1'b1, 4'd4, 77);
    checkOutput("fs_drainwr_err", 32'(err), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'd0, 5);
    model[0] = 5;
    sbq.delete();
    checkOutput("fs_valid", 32'(dout_valid), 32'd0);
    checkOutput("fs_err",   32'(err), 32'd0);
    checkOutput("fs_busy",  32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) writeEntry(i, 90 + i);
    checkOutput("fs_collect", 32'(dout_valid), 32'd0);
    writeEntry(8, 98);
    checkOutput("fs_noerr", 32'(err), 32'd0);
    pushFrame();
    drainFrame("fs", 0, 40, 1'b1, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
